// File: rtl/sfixed_mult_rr_sched_pkg.sv
// ----------------------------------------------------------------------------
// sfixed_pkg
//   Shared types and helpers for the round-robin scheduled fixed-point
//   multiplier.
//   - mult_sched_state_t : scheduler FSM states
//   - sfx_width()        : total width of a signed Q(left).(right) value
// ----------------------------------------------------------------------------
package sfixed_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } mult_sched_state_t;

   // Sign bit + integer bits + fraction bits.
   function automatic int sfx_width(input int left, input int right);
      return left + right + 1;
   endfunction

endpackage

// File: rtl/sfixed_mult_rr_sched_mult.sv
// ----------------------------------------------------------------------------
// sfixed_mult_reg_input
//   Signed fixed-point multiplier with registered operands and a
//   combinational product. The result is the full product re-aligned to
//   Q(OUT_LEFT).(OUT_RIGHT): fraction LSBs truncated, integer MSBs wrapped.
//   Ports:
//     clk     in   1     clock
//     en_a    in   1     load operand A register
//     clr_a   in   1     zero operand A register (wins over en_a)
//     a       in   A_W   operand A, Q(A_LEFT).(A_RIGHT)
//     en_b    in   1     load operand B register
//     clr_b   in   1     zero operand B register (wins over en_b)
//     b       in   B_W   operand B, Q(B_LEFT).(B_RIGHT)
//     result  out  O_W   product of registered operands
// ----------------------------------------------------------------------------
module sfixed_mult_reg_input
   import sfixed_pkg::*;
#(
   parameter int A_LEFT    = 3,
   parameter int A_RIGHT   = 4,
   parameter int B_LEFT    = 3,
   parameter int B_RIGHT   = 4,
   parameter int OUT_LEFT  = 7,
   parameter int OUT_RIGHT = 8
) (
   input  logic                           clk,
   input  logic                           en_a,
   input  logic                           clr_a,
   input  logic [A_LEFT+A_RIGHT:0]        a,
   input  logic                           en_b,
   input  logic                           clr_b,
   input  logic [B_LEFT+B_RIGHT:0]        b,
   output logic [OUT_LEFT+OUT_RIGHT:0]    result
);

   localparam int A_W       = sfx_width(A_LEFT, A_RIGHT);
   localparam int B_W       = sfx_width(B_LEFT, B_RIGHT);
   localparam int O_W       = sfx_width(OUT_LEFT, OUT_RIGHT);
   localparam int FULL_W    = A_W + B_W;
   localparam int FULL_FRAC = A_RIGHT + B_RIGHT;
   // Bit offset from output LSB to the full-product bit of equal weight.
   localparam int SHIFT     = FULL_FRAC - OUT_RIGHT;

   logic signed [A_W-1:0]    r_a;
   logic signed [B_W-1:0]    r_b;
   logic signed [FULL_W-1:0] w_full;
   logic                     w_unused_full;

   always_ff @(posedge clk) begin
      if (clr_a)
         r_a <= '0;
      else if (en_a)
         r_a <= a;
      if (clr_b)
         r_b <= '0;
      else if (en_b)
         r_b <= b;
   end

   assign w_full = r_a * r_b;

   // Per output bit: below the product LSB pads with zero, above the
   // product MSB replicates the sign, otherwise take the aligned bit.
   for (genvar gi = 0; gi < O_W; gi++) begin : g_bit
      if (gi + SHIFT < 0) begin : g_pad
         assign result[gi] = 1'b0;
      end else if (gi + SHIFT >= FULL_W) begin : g_sext
         assign result[gi] = w_full[FULL_W-1];
      end else begin : g_take
         assign result[gi] = w_full[gi+SHIFT];
      end
   end

   // Truncated fraction bits are intentionally dropped.
   assign w_unused_full = ^w_full;

endmodule

// File: rtl/sfixed_mult_rr_sched_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans req starting at ptr+1 (wrapping
//   modulo N_REQ) and reports the first asserted lane.
//   Ports:
//     req    in   N_REQ   request vector
//     ptr    in   ID_W    last granted index
//     any    out  1       at least one request asserted
//     idx    out  ID_W    winning index (0 when any=0)
//     onehot out  N_REQ   one-hot of idx (all zero when any=0)
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             any,
   output logic [ID_W-1:0]  idx,
   output logic [N_REQ-1:0] onehot
);

   // Walk from the farthest offset towards the nearest so that the lane
   // closest after ptr is the last one written, i.e. the winner.
   always_comb begin : pick
      int c;
      any = 1'b0;
      idx = '0;
      c   = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         c = (int'(ptr) + k) % N_REQ;
         if (req[c]) begin
            any = 1'b1;
            idx = ID_W'(c);
         end
      end
   end

   assign onehot = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/sfixed_mult_rr_sched.sv
// ----------------------------------------------------------------------------
// sfixed_mult_rr_sched
//   Round-robin scheduler sharing one sfixed_mult_reg_input between N_REQ
//   requesters. Grant loads the multiplier operand registers, the product is
//   captured one cycle later and held on the response port until accepted.
//   Ports:
//     clk        in   1            clock
//     rst        in   1            synchronous reset, active-high
//     req_valid  in   N_REQ        requester i has operands
//     req_ready  out  N_REQ        one-hot grant, operands of i taken now
//     req_a      in   N_REQ*A_W    packed operand A, lane i at [i*A_W +: A_W]
//     req_b      in   N_REQ*B_W    packed operand B, lane i at [i*B_W +: B_W]
//     rsp_valid  out  1            result held
//     rsp_ready  in   1            consumer accepts result
//     rsp_id     out  ID_W         requester index of the result
//     rsp_data   out  O_W          signed product Q(OUT_LEFT).(OUT_RIGHT)
// ----------------------------------------------------------------------------
module sfixed_mult_rr_sched
   import sfixed_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int A_LEFT    = 3,
   parameter int A_RIGHT   = 4,
   parameter int B_LEFT    = 3,
   parameter int B_RIGHT   = 4,
   parameter int OUT_LEFT  = 7,
   parameter int OUT_RIGHT = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_REQ-1:0]                    req_valid,
   output logic [N_REQ-1:0]                    req_ready,
   input  logic [N_REQ*(A_LEFT+A_RIGHT+1)-1:0] req_a,
   input  logic [N_REQ*(B_LEFT+B_RIGHT+1)-1:0] req_b,
   output logic                                rsp_valid,
   input  logic                                rsp_ready,
   output logic [$clog2(N_REQ)-1:0]            rsp_id,
   output logic [OUT_LEFT+OUT_RIGHT:0]         rsp_data
);

   localparam int A_W  = sfx_width(A_LEFT, A_RIGHT);
   localparam int B_W  = sfx_width(B_LEFT, B_RIGHT);
   localparam int O_W  = sfx_width(OUT_LEFT, OUT_RIGHT);
   localparam int ID_W = $clog2(N_REQ);

   mult_sched_state_t r_state;
   logic [ID_W-1:0]   r_ptr;
   logic [ID_W-1:0]   r_id_q;
   logic              r_rsp_valid;
   logic [ID_W-1:0]   r_rsp_id;
   logic [O_W-1:0]    r_rsp_data;

   logic              w_any;
   logic [ID_W-1:0]   w_idx;
   logic [N_REQ-1:0]  w_onehot;
   logic              w_grant;
   logic              w_load;
   logic [A_W-1:0]    w_a;
   logic [B_W-1:0]    w_b;
   logic [O_W-1:0]    w_prod;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req    (req_valid),
      .ptr    (r_ptr),
      .any    (w_any),
      .idx    (w_idx),
      .onehot (w_onehot)
   );

   // A grant is possible from IDLE, or from RESP when the held result is
   // being accepted this same cycle. Reset suppresses any grant.
   assign w_grant   = !rst && w_any &&
                      ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
   assign req_ready = w_grant ? w_onehot : '0;

   assign w_a = req_a[w_idx*A_W +: A_W];
   assign w_b = req_b[w_idx*B_W +: B_W];

   // During reset both enable and clear are high so operand regs zero out.
   assign w_load = rst || w_grant;

   sfixed_mult_reg_input #(
      .A_LEFT    (A_LEFT),
      .A_RIGHT   (A_RIGHT),
      .B_LEFT    (B_LEFT),
      .B_RIGHT   (B_RIGHT),
      .OUT_LEFT  (OUT_LEFT),
      .OUT_RIGHT (OUT_RIGHT)
   ) u_mult (
      .clk    (clk),
      .en_a   (w_load),
      .clr_a  (rst),
      .a      (w_a),
      .en_b   (w_load),
      .clr_b  (rst),
      .b      (w_b),
      .result (w_prod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= ID_W'(N_REQ - 1);
         r_id_q      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_ptr   <= w_idx;
                  r_id_q  <= w_idx;
                  r_state <= CALC;
               end
            end
            CALC: begin
               // Operand regs were loaded on the grant edge; product is valid.
               r_rsp_data  <= w_prod;
               r_rsp_id    <= r_id_q;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  if (w_grant) begin
                     r_ptr   <= w_idx;
                     r_id_q  <= w_idx;
                     r_state <= CALC;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_sfixed_mult_rr_sched.sv
// ----------------------------------------------------------------------------
// tb_sfixed_mult_rr_sched
//   Self-checking bench for sfixed_mult_rr_sched with default parameters
//   (4 lanes, Q3.4 operands, Q7.8 result). Expected grants come from a
//   round-robin scan over the valid lanes, expected results from integer
//   multiplication of the operands.
// ----------------------------------------------------------------------------
module tb_sfixed_mult_rr_sched;

   localparam int N   = 4;
   localparam int AW  = 8;
   localparam int BW  = 8;
   localparam int OW  = 16;
   localparam int IDW = 2;
   // Full product has 8 fraction bits, result has 8: no shift needed.
   localparam int SH  = (4 + 4) - 8;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [OW-1:0]  data;
   } rsp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_a;
   logic [N*BW-1:0] req_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IDW-1:0]  rsp_id;
   logic [OW-1:0]   rsp_data;

   logic [AW-1:0]   op_a [N];
   logic [BW-1:0]   op_b [N];

   int   n_tests = 0;
   int   n_fail  = 0;
   int   mptr;
   int   w;
   rsp_t exp_q [$];

   sfixed_mult_rr_sched dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < N; i++) begin
         req_a[i*AW +: AW] = op_a[i];
         req_b[i*BW +: BW] = op_b[i];
      end
   end

   function automatic logic [OW-1:0] ref_mul(input logic [AW-1:0] a, input logic [BW-1:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      p = p >>> SH;
      return p[OW-1:0];
   endfunction

   // First valid lane after p, wrapping; -1 when none.
   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 1; k <= N; k++) begin
         if (v[(p + k) % N])
            return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag);
      rsp_t e;
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_id"},    32'(rsp_id),    32'(e.id));
      check({tag, "_data"},  32'(rsp_data),  32'(e.data));
      $display("[TB] %s rsp id=%0d data=%h (exp id=%0d data=%h)", tag, rsp_id, rsp_data, e.id, e.data);
   endtask

   // One isolated operation on a single lane with rsp_ready held high.
   task automatic single(input string tag, input int lane, input logic [AW-1:0] a,
                         input logic [BW-1:0] b, input logic [OW-1:0] exp);
      op_a[lane] = a;
      op_b[lane] = b;
      req_valid  = N'(1) << lane;
      rsp_ready  = 1'b1;
      @(negedge clk);
      check({tag, "_grant"}, 32'(req_ready), 32'(N'(1) << lane));
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      check({tag, "_calc_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_calc_valid"}, 32'(rsp_valid), 32'd0);
      next_cycle();
      @(negedge clk);
      exp_q.push_back('{id: IDW'(lane), data: exp});
      check_rsp(tag);
      next_cycle();
      @(negedge clk);
      check({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
      next_cycle();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         op_a[i] = AW'($urandom);
         op_b[i] = BW'($urandom);
      end

      // Reset held with every lane requesting.
      repeat (2) begin
         @(negedge clk);
         check("rst_req_ready", 32'(req_ready), 32'd0);
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_rsp_data",  32'(rsp_data),  32'd0);
      end
      next_cycle();
      req_valid = '0;
      rst       = 1'b0;

      // Directed arithmetic cases.
      single("mul_1p5x2",  0, 8'h18, 8'h20, 16'h0300);
      single("mul_m1x0p5", 2, 8'hF0, 8'h08, 16'hFF80);
      single("mul_minmin", 1, 8'h80, 8'h80, 16'h4000);
      single("mul_maxmin", 3, 8'h7F, 8'h80, ref_mul(8'h7F, 8'h80));

      // Random single operations on random lanes.
      repeat (6) begin
         int            lane;
         logic [AW-1:0] ra;
         logic [BW-1:0] rb;
         lane = int'($urandom_range(0, N - 1));
         ra   = AW'($urandom);
         rb   = BW'($urandom);
         single("mul_rand", lane, ra, rb, ref_mul(ra, rb));
      end

      // Fairness: reset the pointer, then all lanes request continuously.
      rst = 1'b1;
      next_cycle();
      rst       = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      mptr      = N - 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k % 2 == 0) begin
            w = pick(req_valid, mptr);
            check("fair_grant", 32'(req_ready), 32'(N'(1) << w));
            if (k >= 2)
               check_rsp("fair");
            exp_q.push_back('{id: IDW'(w), data: ref_mul(op_a[w], op_b[w])});
            mptr = w;
            next_cycle();
            op_a[w] = AW'($urandom);
            op_b[w] = BW'($urandom);
         end else begin
            check("fair_calc_ready", 32'(req_ready), 32'd0);
            check("fair_calc_valid", 32'(rsp_valid), 32'd0);
            next_cycle();
         end
      end

      // Backpressure: result must hold and no lane may be granted.
      rsp_ready = 1'b0;
      repeat (5) begin
         rsp_t e;
         @(negedge clk);
         e = exp_q[0];
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_id",    32'(rsp_id),    32'(e.id));
         check("bp_data",  32'(rsp_data),  32'(e.data));
         check("bp_ready", 32'(req_ready), 32'd0);
         next_cycle();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      w = pick(req_valid, mptr);
      check("bp_release_grant", 32'(req_ready), 32'(N'(1) << w));
      check_rsp("bp_release");
      exp_q.push_back('{id: IDW'(w), data: ref_mul(op_a[w], op_b[w])});
      mptr = w;
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      check("drain_calc_valid", 32'(rsp_valid), 32'd0);
      next_cycle();
      @(negedge clk);
      check_rsp("drain");
      next_cycle();
      @(negedge clk);
      check("drain_idle_valid", 32'(rsp_valid), 32'd0);
      next_cycle();

      // Reset while an operation is in CALC drops it and restarts at lane 0.
      req_valid = 4'b0100;
      @(negedge clk);
      check("rstcalc_grant", 32'(req_ready), 32'b0100);
      next_cycle();
      req_valid = '1;
      rst       = 1'b1;
      @(negedge clk);
      check("rstcalc_no_ready", 32'(req_ready), 32'd0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rstcalc_dropped", 32'(rsp_valid), 32'd0);
      check("rstcalc_first",   32'(req_ready), 32'b0001);
      exp_q.push_back('{id: IDW'(0), data: ref_mul(op_a[0], op_b[0])});
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      check("rstcalc_calc_valid", 32'(rsp_valid), 32'd0);
      next_cycle();
      @(negedge clk);
      check_rsp("rstcalc_after");
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
